// File: rtl/pc_fetch_unit_pkg.sv
// Shared FSM encoding and default widths for the PC / instruction-fetch stage.
package pc_fetch_unit_pkg;

    localparam int ADDR_W_DEF     = 64;
    localparam int INSTR_W_DEF    = 32;
    localparam int ALIGN_BITS_DEF = 2;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

endpackage

// File: rtl/pc_fetch_unit_pc_register.sv
// Architectural PC: loads start_pc during reset, next_pc when load_en; 1-cycle update.
// Also flags whether next_pc meets the alignment rule; no backpressure of its own.
module pc_fetch_unit_pc_register #(
    parameter int ADDR_W     = 64,
    parameter int ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              load_en,
    output logic [ADDR_W-1:0] pc,
    output logic              next_aligned
);

    assign next_aligned = (next_pc[ALIGN_BITS-1:0] == '0);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            pc <= start_pc;
        end else if (load_en) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC + single-outstanding fetch stage; 3 cycles/instr with zero-wait memory (accept, respond, retire).
// Request held stable until imem_req_ready; instruction held until pc_advance. FETCH_PERF_EN adds perf counters.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int ALIGN_BITS = ALIGN_BITS_DEF
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  startPC,
    input  logic [ADDR_W-1:0]  NextPC,
    input  logic               pc_advance,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [ADDR_W-1:0]  CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               instr_valid,
    output logic               pc_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_cycles
`endif
);

    logic [1:0] state;
    logic       next_aligned;
    logic       accept;
    logic       pc_load;

    assign imem_req_valid = Reset_L && (state == ST_FETCH);
    assign imem_req_addr  = CurrentPC;
    assign instr_valid    = (state == ST_READY);
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_load        = (state == ST_READY) && pc_advance && next_aligned;

    pc_fetch_unit_pc_register #(
        .ADDR_W     (ADDR_W),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_pc_register (
        .clk          (CLK),
        .reset_l      (Reset_L),
        .start_pc     (startPC),
        .next_pc      (NextPC),
        .load_en      (pc_load),
        .pc           (CurrentPC),
        .next_aligned (next_aligned)
    );

    // Responses are only taken in WAIT, so a late response after reset is dropped.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state       <= ST_FETCH;
            Instruction <= '0;
            pc_fault    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: if (accept) state <= ST_WAIT;
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        Instruction <= imem_rsp_data;
                        state       <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (pc_advance) begin
                        if (next_aligned) begin
                            state <= ST_FETCH;
                        end else begin
                            state    <= ST_FAULT;
                            pc_fault <= 1'b1;
                        end
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_FAULT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic stall;

    assign stall = ((state == ST_FETCH) && !imem_req_ready) ||
                   ((state == ST_WAIT) && !imem_rsp_valid);

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            fetch_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
